// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and the memory stage, data first.
// Optional watchdog built when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          stall_f,
    output logic          stall_m,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          bus_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_D = 2'd1;
    localparam logic [1:0] BUSY_I = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_valid_q, i_valid_d;
    logic          d_valid_q, d_valid_d;
    logic          finish;
    logic          expired;
    logic [DW-1:0] resp;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt_q, cnt_d;
    logic       bus_err_q, bus_err_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    // The watchdog limit only matters when the watchdog is built.
    logic unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT_CYCLES);
    assign bus_err        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_valid_d   = 1'b0;
        d_valid_d   = 1'b0;
        finish      = 1'b0;
        expired     = 1'b0;
        resp        = '0;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = '0;
        bus_err_d   = bus_err_q;
`endif
        case (state_q)
            IDLE: begin
                // A requester whose valid is showing this cycle is not regranted.
                if (d_req && !d_valid_q) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (i_req && !i_valid_q) begin
                    state_d    = BUSY_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_addr;
                end
            end
            BUSY_D, BUSY_I: begin
                if (mem_ready) begin
                    finish = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LIM - 8'd1) begin
                    finish  = 1'b1;
                    expired = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
                resp = (mem_we_q || expired) ? '0 : mem_rdata;
                if (finish) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == BUSY_D) begin
                        d_valid_d = 1'b1;
                        d_rdata_d = resp;
                    end else begin
                        i_valid_d = 1'b1;
                        i_rdata_d = resp;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef ARB_TIMEOUT_EN
        bus_err_d = bus_err_q | expired;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_valid_q   <= i_valid_d;
            d_valid_q   <= d_valid_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_valid   = i_valid_q;
    assign d_valid   = d_valid_q;
    // Stalls come straight from req/valid, never from mem_ready.
    assign stall_f   = i_req & ~i_valid_q;
    assign stall_m   = d_req & ~d_valid_q;

endmodule
